cpu_trace_checker: RTL and testbench
====================================

// Module: cpu_trace_checker
// PURPOSE
//  Byte-serial parser for CPU trace records, one ASCII char per clock. Two formats:
//  register "^<time>@<pc>: $<grf> <= <data>#" and memory "^<time>@<pc>: *<addr> <= <data>#".
//  Parametrised successor of the single-format checker: configurable field lengths, semantic
//  error flags, captured field values and a valid-record counter. Sits between trace source and scoreboard.
// PARAMETERS
//  TIME_DIGITS  4       max decimal digits of <time> (min 1)
//  GRF_DIGITS   4       max decimal digits of <grf> (min 1)
//  PC_LO        32'h3000 lowest legal pc (inclusive)
//  PC_HI        32'h6ffc highest legal pc (inclusive)
//  CNT_W        16      width of valid-record counter
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high
//  char         in   8      ASCII char, sampled every rising edge
//  format_type  out  2      0 none/invalid, 1 register record, 2 memory record
//  error_code   out  4      [0] pc misaligned/out of range [1] addr misaligned [2] grf>31 [3] time==0
//  rec_pc       out  32     pc of last completed record
//  rec_target   out  32     grf index (zero-extended) or addr of last completed record
//  rec_data     out  32     data of last completed record
//  rec_count    out  CNT_W  number of syntactically valid records since reset
// BEHAVIOUR
//  - Reset: all outputs 0; FSM -> IDLE. Reset wins over char in the same cycle.
//  - Lexing: decimal = '0'-'9'; hex = '0'-'9','a'-'f','A'-'F'. <pc>,<addr>,<data> exactly 8 hex.
//    <time> 1..TIME_DIGITS dec; <grf> 1..GRF_DIGITS dec. Spaces: zero or more after ':', before
//    and after "<=". No spaces elsewhere.
//  - States: IDLE, TIME, PC, COLON_SP, GRF, ADDR, PRE_ARROW, ARROW_LT (after '<'), POST_ARROW,
//    DATA, DONE, ERROR.
//  - '^' in any state (incl. DONE/ERROR/mid-record) -> TIME with digit counters and accumulators
//    cleared. Any char illegal for the current state -> ERROR; ERROR waits for '^'.
//  - Digit-count overflow (9th hex digit, TIME_DIGITS+1 decimal) -> ERROR. '@' after 0 time
//    digits, ':' after <8 pc digits, '<' after <1/<8 digits, '#' after <8 data digits -> ERROR.
//  - '#' in DATA with 8 digits: on that edge FSM -> DONE; format_type, error_code, rec_* load,
//    rec_count += 1 (wraps modulo 2^CNT_W). Latency: outputs valid the cycle after '#' is sampled.
//  - format_type/error_code are nonzero only while in DONE; they return to 0 on the next edge
//    (next char leaves DONE: '^' -> TIME, anything else -> IDLE). rec_* and rec_count hold
//    until the next valid record or reset.
//  - error_code is semantic only, computed from accumulated values; record still counts as
//    valid: bit0 = pc[1:0]!=0 || pc<PC_LO || pc>PC_HI; bit1 = addr[1:0]!=0 (mem only);
//    bit2 = grf>31 (reg only); bit3 = time==0. Register record: bit1=0; memory: bit2=0.
//  - Accumulators: hex shift acc = {acc[27:0],nibble}; decimal acc = acc*10+d, saturating at
//    32'hFFFF_FFFF (grf and time only).
//  - Invalid/aborted records leave rec_*, rec_count unchanged.
// STRUCTURE
//  - Package cpu_trace_pkg: state enum, format codes (FMT_NONE/REG/MEM), error bit indices,
//    ASCII constants ('^','@',':','$','*','<','=','#',' ').
//  - Sub-module cpu_char_class (combinational): char -> is_dec, is_hex, nibble[3:0].
//  - Top: FSM, digit counter, three 32-bit accumulators, output registers.
// TESTING
//  1 "^338@00003130: *00000088 <= fffb5280#" -> format_type=2, error_code=0, rec_pc=3130,
//    rec_target=88, rec_data=fffb5280, rec_count=1 for one cycle after '#'.
//  2 Same record with data "fffb528#" (7 digits) -> format_type stays 0, rec_count unchanged.
//  3 "^12@00003002:$40<=0000ABCD#" -> format_type=1, error_code=4'b0101, rec_target=40.
//  4 "^0@00003000: *00000086 <= 00000001#" -> format_type=2, error_code=4'b1010.
//  5 "^33@00003" then "^5@00003004: $1 <= 00000000#" -> restart, format_type=1, count+1.
//  6 reset asserted mid-record and in DONE cycle -> all outputs 0 next edge; "^12345@" with
//    TIME_DIGITS=4 -> ERROR, no output until next '^'; count wrap with CNT_W=2 after 4 records.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the CPU trace record checker.
// Holds the parser state encoding, record format codes, error bit positions and ASCII tokens.
package cpu_trace_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TIME,
        ST_PC,
        ST_COLON_SP,
        ST_GRF,
        ST_ADDR,
        ST_PRE_ARROW,
        ST_ARROW_LT,
        ST_POST_ARROW,
        ST_DATA,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [1:0] FMT_NONE = 2'd0;
    localparam logic [1:0] FMT_REG  = 2'd1;
    localparam logic [1:0] FMT_MEM  = 2'd2;

    localparam int ERR_PC   = 0;
    localparam int ERR_ADDR = 1;
    localparam int ERR_GRF  = 2;
    localparam int ERR_TIME = 3;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_LT     = 8'h3C;
    localparam logic [7:0] CH_EQ     = 8'h3D;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    localparam logic [7:0] HEX_FIELD_DIGITS = 8'd8;

    // Decimal accumulate that pins at all-ones instead of wrapping.
    function automatic logic [31:0] dec_shift(input logic [31:0] acc, input logic [3:0] d);
        logic [35:0] wide;
        wide = ({4'd0, acc} * 36'd10) + {32'd0, d};
        return (wide[35:32] != 4'd0) ? 32'hFFFF_FFFF : wide[31:0];
    endfunction

    function automatic logic [31:0] hex_shift(input logic [31:0] acc, input logic [3:0] d);
        return {acc[27:0], d};
    endfunction

endpackage

// File: rtl/cpu_char_class.sv
// Classifies one ASCII character as decimal / hex digit and yields its nibble value.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input character.
module cpu_char_class (
    input  logic [7:0] char,
    output logic       is_dec,
    output logic       is_hex,
    output logic [3:0] nibble
);

    always_comb begin
        is_dec = 1'b0;
        is_hex = 1'b0;
        nibble = 4'd0;
        if (char >= 8'h30 && char <= 8'h39) begin
            is_dec = 1'b1;
            is_hex = 1'b1;
            nibble = char[3:0];
        end else if ((char >= 8'h61 && char <= 8'h66) || (char >= 8'h41 && char <= 8'h46)) begin
            // 'a'/'A' have low nibble 1, so +9 maps them onto 10..15
            is_hex = 1'b1;
            nibble = char[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/cpu_trace_checker.sv
// Byte-serial parser/checker for register and memory CPU trace records, one char per clock.
// Latency: record results appear on the cycle after the terminating '#' is sampled.
// Backpressure: none; a character is consumed on every rising edge.
module cpu_trace_checker
    import cpu_trace_pkg::*;
#(
    parameter int          TIME_DIGITS = 4,
    parameter int          GRF_DIGITS  = 4,
    parameter logic [31:0] PC_LO       = 32'h3000,
    parameter logic [31:0] PC_HI       = 32'h6ffc,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    output logic [1:0]       format_type,
    output logic [3:0]       error_code,
    output logic [31:0]      rec_pc,
    output logic [31:0]      rec_target,
    output logic [31:0]      rec_data,
    output logic [CNT_W-1:0] rec_count
);

    localparam logic [7:0] TIME_MAX = 8'(TIME_DIGITS);
    localparam logic [7:0] GRF_MAX  = 8'(GRF_DIGITS);

    state_t      state_q, state_d;
    logic [7:0]  dig_cnt_q, dig_cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] data_q, data_d;
    logic        time_zero_q, time_zero_d;
    logic        is_mem_q, is_mem_d;
    logic        rec_done;
    logic [3:0]  err_d;

    logic        is_dec, is_hex;
    logic [3:0]  nibble;
    logic        is_space, is_lt;
    logic [7:0]  dig_cnt_inc;

    cpu_char_class u_char_class (
        .char   (char),
        .is_dec (is_dec),
        .is_hex (is_hex),
        .nibble (nibble)
    );

    assign is_space    = (char == CH_SPACE);
    assign is_lt       = (char == CH_LT);
    assign dig_cnt_inc = dig_cnt_q + 8'd1;

    // The time field is accumulated in data_q; only its zero-ness survives past '@'.
    always_comb begin
        state_d     = state_q;
        dig_cnt_d   = dig_cnt_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        data_d      = data_q;
        time_zero_d = time_zero_q;
        is_mem_d    = is_mem_q;
        rec_done    = 1'b0;

        if (char == CH_CARET) begin
            state_d     = ST_TIME;
            dig_cnt_d   = 8'd0;
            pc_d        = 32'd0;
            tgt_d       = 32'd0;
            data_d      = 32'd0;
            time_zero_d = 1'b0;
            is_mem_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ERROR: ;
                ST_DONE: state_d = ST_IDLE;
                ST_TIME: begin
                    if (is_dec && dig_cnt_q < TIME_MAX) begin
                        data_d    = dec_shift(data_q, nibble);
                        dig_cnt_d = dig_cnt_inc;
                    end else if (char == CH_AT && dig_cnt_q != 8'd0) begin
                        state_d     = ST_PC;
                        dig_cnt_d   = 8'd0;
                        time_zero_d = (data_q == 32'd0);
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
                ST_PC: begin
                    if (is_hex && dig_cnt_q < HEX_FIELD_DIGITS) begin
                        pc_d      = hex_shift(pc_q, nibble);
                        dig_cnt_d = dig_cnt_inc;
                    end else if (char == CH_COLON && dig_cnt_q == HEX_FIELD_DIGITS) begin
                        state_d = ST_COLON_SP;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
                ST_COLON_SP: begin
                    if (char == CH_DOLLAR) begin
                        state_d   = ST_GRF;
                        is_mem_d  = 1'b0;
                        dig_cnt_d = 8'd0;
                    end else if (char == CH_STAR) begin
                        state_d   = ST_ADDR;
                        is_mem_d  = 1'b1;
                        dig_cnt_d = 8'd0;
                    end else if (!is_space) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_GRF: begin
                    if (is_dec && dig_cnt_q < GRF_MAX) begin
                        tgt_d     = dec_shift(tgt_q, nibble);
                        dig_cnt_d = dig_cnt_inc;
                    end else if ((is_space || is_lt) && dig_cnt_q != 8'd0) begin
                        state_d = is_space ? ST_PRE_ARROW : ST_ARROW_LT;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
                ST_ADDR: begin
                    if (is_hex && dig_cnt_q < HEX_FIELD_DIGITS) begin
                        tgt_d     = hex_shift(tgt_q, nibble);
                        dig_cnt_d = dig_cnt_inc;
                    end else if ((is_space || is_lt) && dig_cnt_q == HEX_FIELD_DIGITS) begin
                        state_d = is_space ? ST_PRE_ARROW : ST_ARROW_LT;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
                ST_PRE_ARROW: begin
                    if (is_lt) begin
                        state_d = ST_ARROW_LT;
                    end else if (!is_space) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_ARROW_LT: state_d = (char == CH_EQ) ? ST_POST_ARROW : ST_ERROR;
                ST_POST_ARROW: begin
                    if (is_hex) begin
                        state_d   = ST_DATA;
                        data_d    = {28'd0, nibble};
                        dig_cnt_d = 8'd1;
                    end else if (!is_space) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_DATA: begin
                    if (is_hex && dig_cnt_q < HEX_FIELD_DIGITS) begin
                        data_d    = hex_shift(data_q, nibble);
                        dig_cnt_d = dig_cnt_inc;
                    end else if (char == CH_HASH && dig_cnt_q == HEX_FIELD_DIGITS) begin
                        state_d  = ST_DONE;
                        rec_done = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
                default: state_d = ST_ERROR;
            endcase
        end
    end

    always_comb begin
        err_d           = 4'd0;
        err_d[ERR_PC]   = (pc_q[1:0] != 2'd0) || (pc_q < PC_LO) || (pc_q > PC_HI);
        err_d[ERR_ADDR] = is_mem_q && (tgt_q[1:0] != 2'd0);
        err_d[ERR_GRF]  = !is_mem_q && (tgt_q > 32'd31);
        err_d[ERR_TIME] = time_zero_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dig_cnt_q   <= 8'd0;
            pc_q        <= 32'd0;
            tgt_q       <= 32'd0;
            data_q      <= 32'd0;
            time_zero_q <= 1'b0;
            is_mem_q    <= 1'b0;
            format_type <= FMT_NONE;
            error_code  <= 4'd0;
            rec_pc      <= 32'd0;
            rec_target  <= 32'd0;
            rec_data    <= 32'd0;
            rec_count   <= '0;
        end else begin
            state_q     <= state_d;
            dig_cnt_q   <= dig_cnt_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            data_q      <= data_d;
            time_zero_q <= time_zero_d;
            is_mem_q    <= is_mem_d;
            // Format and error are a one-cycle DONE strobe; rec_* are sticky.
            format_type <= FMT_NONE;
            error_code  <= 4'd0;
            if (rec_done) begin
                format_type <= is_mem_q ? FMT_MEM : FMT_REG;
                error_code  <= err_d;
                rec_pc      <= pc_q;
                rec_target  <= tgt_q;
                rec_data    <= data_q;
                rec_count   <= rec_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Directed table vectors, multi-cycle corner sequences and randomized records checked
// against a string-level grammar model of the trace format.
module tb_cpu_trace_checker;

    localparam int          TD = 4;
    localparam int          GD = 4;
    localparam int          CW = 2;
    localparam logic [31:0] LO = 32'h3000;
    localparam logic [31:0] HI = 32'h6ffc;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    char;
    logic [1:0]    format_type;
    logic [3:0]    error_code;
    logic [31:0]   rec_pc, rec_target, rec_data;
    logic [CW-1:0] rec_count;

    always #5 clk = ~clk;

    cpu_trace_checker #(
        .TIME_DIGITS (TD),
        .GRF_DIGITS  (GD),
        .PC_LO       (LO),
        .PC_HI       (HI),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .char        (char),
        .format_type (format_type),
        .error_code  (error_code),
        .rec_pc      (rec_pc),
        .rec_target  (rec_target),
        .rec_data    (rec_data),
        .rec_count   (rec_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    string       m_buf;
    bit          m_act;
    logic [1:0]  m_fmt;
    logic [3:0]  m_err;
    logic [31:0] m_pc, m_tgt, m_data;
    int          m_cnt;

    typedef struct {
        string       s;
        bit          vld;
        logic [1:0]  fmt;
        logic [3:0]  err;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [31:0] data;
    } vec_t;
    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] f, input logic [3:0] e,
                             input logic [31:0] p, input logic [31:0] t, input logic [31:0] d,
                             input int c);
        check($sformatf("%s.format_type", tag), 32'(format_type), 32'(f));
        check($sformatf("%s.error_code", tag), 32'(error_code), 32'(e));
        check($sformatf("%s.rec_pc", tag), rec_pc, p);
        check($sformatf("%s.rec_target", tag), rec_target, t);
        check($sformatf("%s.rec_data", tag), rec_data, d);
        check($sformatf("%s.rec_count", tag), 32'(rec_count), 32'(c));
    endtask

    function automatic int hexval(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        return -1;
    endfunction

    function automatic bit is_digit(input logic [7:0] c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction

    function automatic bit hex8(input string s, input int i, output logic [31:0] v);
        int h;
        v = 32'd0;
        if (i + 8 > s.len()) return 1'b0;
        for (int k = 0; k < 8; k++) begin
            h = hexval(s[i+k]);
            if (h < 0) return 1'b0;
            v = (v << 4) | 32'(h);
        end
        return 1'b1;
    endfunction

    // Reads a decimal run starting at i; returns its length and its saturated value.
    function automatic int dec_run(input string s, inout int i, output logic [31:0] v);
        longint acc;
        int     k;
        acc = 0;
        k = 0;
        while (i < s.len() && is_digit(s[i])) begin
            acc = acc * 10 + longint'(hexval(s[i]));
            if (acc > 64'h0000_0000_FFFF_FFFF) acc = 64'h0000_0000_FFFF_FFFF;
            i++;
            k++;
        end
        v = acc[31:0];
        return k;
    endfunction

    // Whole-record grammar check on the text between '^' and '#'.
    function automatic bit parse(input string s, output logic [1:0] fmt, output logic [31:0] tim,
                                 output logic [31:0] pc, output logic [31:0] tgt,
                                 output logic [31:0] data);
        int i, n, k;
        fmt = 2'd0; tim = 32'd0; pc = 32'd0; tgt = 32'd0; data = 32'd0;
        i = 0;
        n = s.len();
        k = dec_run(s, i, tim);
        if (k < 1 || k > TD) return 1'b0;
        if (i >= n || s[i] != "@") return 1'b0;
        i++;
        if (!hex8(s, i, pc)) return 1'b0;
        i += 8;
        if (i >= n || s[i] != ":") return 1'b0;
        i++;
        while (i < n && s[i] == " ") i++;
        if (i >= n) return 1'b0;
        if (s[i] == "$") begin
            fmt = 2'd1;
            i++;
            k = dec_run(s, i, tgt);
            if (k < 1 || k > GD) return 1'b0;
        end else if (s[i] == "*") begin
            fmt = 2'd2;
            i++;
            if (!hex8(s, i, tgt)) return 1'b0;
            i += 8;
        end else begin
            return 1'b0;
        end
        while (i < n && s[i] == " ") i++;
        if (i + 1 >= n || s[i] != "<" || s[i+1] != "=") return 1'b0;
        i += 2;
        while (i < n && s[i] == " ") i++;
        if (!hex8(s, i, data)) return 1'b0;
        i += 8;
        return i == n;
    endfunction

    task automatic model_reset();
        m_buf = ""; m_act = 1'b0;
        m_fmt = 2'd0; m_err = 4'd0;
        m_pc = 32'd0; m_tgt = 32'd0; m_data = 32'd0; m_cnt = 0;
    endtask

    task automatic model_step(input logic [7:0] c);
        logic [1:0]  f;
        logic [31:0] t, p, g, d;
        string       one;
        m_fmt = 2'd0;
        m_err = 4'd0;
        if (c == "^") begin
            m_buf = "";
            m_act = 1'b1;
        end else if (m_act) begin
            if (c == "#") begin
                m_act = 1'b0;
                if (parse(m_buf, f, t, p, g, d)) begin
                    m_fmt  = f;
                    m_err  = {t == 0, f == 2'd1 && g > 31, f == 2'd2 && g % 4 != 0,
                              p % 4 != 0 || p < LO || p > HI};
                    m_pc   = p;
                    m_tgt  = g;
                    m_data = d;
                    m_cnt  = (m_cnt + 1) % (1 << CW);
                end
            end else begin
                one = " ";
                one[0] = c;
                m_buf = {m_buf, one};
            end
        end
    endtask

    task automatic step(input logic [7:0] c);
        char = c;
        @(posedge clk);
        #1;
        model_step(c);
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) step(s[i]);
    endtask

    task automatic pulse_reset(input logic [7:0] c);
        reset = 1'b1;
        char = c;
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
    endtask

    task automatic add_vec(input string s, input bit vld, input logic [1:0] f, input logic [3:0] e,
                           input logic [31:0] p, input logic [31:0] t, input logic [31:0] d);
        vec_t v;
        v.s = s; v.vld = vld; v.fmt = f; v.err = e; v.pc = p; v.tgt = t; v.data = d;
        vt.push_back(v);
    endtask

    function automatic string spaces(input int n);
        string r;
        r = "";
        for (int i = 0; i < n; i++) r = {r, " "};
        return r;
    endfunction

    function automatic string hx(input logic [31:0] v);
        if ($urandom_range(0, 1) == 0) return $sformatf("%08x", v);
        return $sformatf("%08X", v);
    endfunction

    function automatic string gen_rec();
        string       s, t, js;
        logic [31:0] pc;
        int          sel;
        s = ($urandom_range(0, 5) == 0) ? "x9 ^" : "^";
        sel = $urandom_range(0, 9);
        if (sel == 0) t = "0";
        else if (sel == 1) t = "12345";
        else t = $sformatf("%0d", $urandom_range(1, 9999));
        s = {s, t, "@"};
        if ($urandom_range(0, 3) == 0) pc = $urandom();
        else pc = 32'h2ff0 + 32'($urandom_range(0, 16400));
        s = {s, hx(pc), ":", spaces($urandom_range(0, 2))};
        if ($urandom_range(0, 1) == 0) begin
            if ($urandom_range(0, 9) == 0) t = "12345";
            else t = $sformatf("%0d", $urandom_range(0, 63));
            s = {s, "$", t};
        end else begin
            s = {s, "*", hx($urandom())};
        end
        s = {s, spaces($urandom_range(0, 2)), "<=", spaces($urandom_range(0, 2))};
        sel = $urandom_range(0, 9);
        t = hx($urandom());
        if (sel == 0) t = t.substr(0, 6);
        else if (sel == 1) t = {t, "a"};
        s = {s, t, "#"};
        if ($urandom_range(0, 7) == 0) begin
            js = "0aZ:^# $<=*@g";
            s[$urandom_range(1, s.len() - 1)] = js[$urandom_range(0, js.len() - 1)];
        end
        return s;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          tc;
        logic [31:0] lp, lt, ld;
        string       s;

        add_vec("^338@00003130: *00000088 <= fffb5280#", 1, 2'd2, 4'b0000, 32'h3130, 32'h88, 32'hfffb5280);
        add_vec("^338@00003130: *00000088 <= fffb528#",  0, 2'd0, 4'b0000, 32'h0, 32'h0, 32'h0);
        add_vec("^12@00003002:$40<=0000ABCD#",           1, 2'd1, 4'b0101, 32'h3002, 32'd40, 32'h0000abcd);
        add_vec("^0@00003000: *00000086 <= 00000001#",   1, 2'd2, 4'b1010, 32'h3000, 32'h86, 32'h1);
        add_vec("^12345@00003000: $1 <= 00000000#",      0, 2'd0, 4'b0000, 32'h0, 32'h0, 32'h0);
        add_vec("^1@00007000: $31 <= 12345678#",         1, 2'd1, 4'b0001, 32'h7000, 32'd31, 32'h12345678);
        add_vec("^9999@00006ffc:  *0000FFFC   <=  DEADbeef#", 1, 2'd2, 4'b0000, 32'h6ffc, 32'hfffc, 32'hdeadbeef);
        add_vec("^1@00003000 : $1 <= 00000000#",         0, 2'd0, 4'b0000, 32'h0, 32'h0, 32'h0);
        add_vec("^1@00003000: $1 < = 00000000#",         0, 2'd0, 4'b0000, 32'h0, 32'h0, 32'h0);
        add_vec("^1@00003000: $ 1 <= 00000000#",         0, 2'd0, 4'b0000, 32'h0, 32'h0, 32'h0);
        add_vec("^1@0000300g0: $1 <= 00000000#",         0, 2'd0, 4'b0000, 32'h0, 32'h0, 32'h0);
        add_vec("1@00003000: $1 <= 00000000#",           0, 2'd0, 4'b0000, 32'h0, 32'h0, 32'h0);
        add_vec("^2@00003ffd: $00031 <= 00000000#",      0, 2'd0, 4'b0000, 32'h0, 32'h0, 32'h0);
        add_vec("^2@00002ffc: $0031 <= 00000000#",       1, 2'd1, 4'b0001, 32'h2ffc, 32'd31, 32'h0);

        reset = 1'b1;
        char = 8'h5E;
        @(posedge clk);
        #1;
        model_reset();
        check_all("reset", 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 0);
        reset = 1'b0;

        tc = 0; lp = 32'd0; lt = 32'd0; ld = 32'd0;
        for (int i = 0; i < vt.size(); i++) begin
            send(vt[i].s);
            if (vt[i].vld) begin
                tc = (tc + 1) % (1 << CW);
                lp = vt[i].pc; lt = vt[i].tgt; ld = vt[i].data;
                check_all($sformatf("vec%0d", i), vt[i].fmt, vt[i].err, lp, lt, ld, tc);
            end else begin
                check_all($sformatf("vec%0d", i), 2'd0, 4'd0, lp, lt, ld, tc);
            end
            step(" ");
            check_all($sformatf("vec%0d.clr", i), 2'd0, 4'd0, lp, lt, ld, tc);
        end

        send("^33@00003");
        send("^5@00003004: $1 <= 00000000#");
        tc = (tc + 1) % (1 << CW);
        check_all("restart", 2'd1, 4'd0, 32'h3004, 32'd1, 32'd0, tc);

        send("^5@00003004: $1 <= 0000");
        pulse_reset("0");
        check_all("rst_mid", 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 0);
        send("^7@00003008: $2 <= 0000000");
        pulse_reset("#");
        check_all("rst_wins", 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 0);
        step("#");
        check_all("rst_after", 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 0);

        send("^7@00003008: $2 <= 00000001#");
        check_all("pre_rst", 2'd1, 4'd0, 32'h3008, 32'd2, 32'd1, 1);
        pulse_reset("^");
        check_all("rst_done", 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 0);

        for (int k = 1; k <= 4; k++) begin
            send($sformatf("^1@0000300C: *00000010 <= %08x#", k));
            check_all($sformatf("wrap%0d", k), 2'd2, 4'd0, 32'h300c, 32'h10, 32'(k), k % 4);
        end

        for (int r = 0; r < 250; r++) begin
            s = gen_rec();
            for (int i = 0; i < s.len(); i++) begin
                step(s[i]);
                check_all($sformatf("rand%0d.%0d", r, i), m_fmt, m_err, m_pc, m_tgt, m_data, m_cnt);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
